game_status_tx: RTL

// UART transmitter reporting game status to the host PC: the return path of the

---
 rtl/game_status_if.sv | 14 +
 rtl/game_status_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/game_status_if.sv
// Status-report bundle between the game control logic and the UART status transmitter.
interface game_status_if;
  logic       en;
  logic [2:0] state;
  logic [5:0] score;
  logic       tx;
  logic       busy;
  logic       line_done;

  modport master (output en, output state, output score,
                  input  tx, input  busy, input  line_done);
  modport slave  (input  en, input  state, input  score,
                  output tx, output busy, output line_done);
endinterface

// File: rtl/game_status_tx.sv
// Sends "S<state> <tens><units>\r\n" as 8N1 UART frames whenever game state or score
// changes; changes arriving while a line is in flight coalesce into one later line.
module game_status_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic          clk,
  input  logic          rst,
  game_status_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [2:0]       sent_state;
  logic [5:0]       sent_score;
  logic [2:0]       snap_state;
  logic [5:0]       snap_score;
  logic             tx_r;
  logic             busy_r;
  logic             line_done_r;

  logic             bit_end;
  logic             start_line;
  logic [2:0]       next_bit;
  logic [7:0]       cur_byte;

  // Score digits use 7-bit arithmetic so nothing is truncated for 0..63.
  function automatic logic [7:0] tens_char(input logic [5:0] s);
    logic [6:0] s7;
    logic [6:0] t;
    s7 = {1'b0, s};
    t  = s7 / 7'd10;
    return 8'h30 + {1'b0, t};
  endfunction

  function automatic logic [7:0] units_char(input logic [5:0] s);
    logic [6:0] s7;
    logic [6:0] t;
    logic [6:0] u;
    s7 = {1'b0, s};
    t  = s7 / 7'd10;
    u  = s7 - (t * 7'd10);
    return 8'h30 + {1'b0, u};
  endfunction

  assign bit_end    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign start_line = (fsm == IDLE) && bus.en &&
                      ((bus.state != sent_state) || (bus.score != sent_score));
  assign next_bit   = bit_idx + 3'd1;

  always_comb begin
    cur_byte = 8'h53;
    case (byte_idx)
      3'd0:    cur_byte = 8'h53;
      3'd1:    cur_byte = 8'h30 + {5'd0, snap_state};
      3'd2:    cur_byte = 8'h20;
      3'd3:    cur_byte = tens_char(snap_score);
      3'd4:    cur_byte = units_char(snap_score);
      3'd5:    cur_byte = 8'h0D;
      3'd6:    cur_byte = 8'h0A;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Snapshot stage: the line content is frozen when the line starts.
  always_ff @(posedge clk) begin
    if (start_line) begin
      snap_state <= bus.state;
      snap_score <= bus.score;
    end
  end

  // Serializer stage: one start bit, 8 data bits LSB first, one stop bit per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      line_done_r <= 1'b0;
      clk_cnt     <= '0;
      bit_idx     <= 3'd0;
      byte_idx    <= 3'd0;
      sent_state  <= 3'b111;
      sent_score  <= 6'd0;
    end else begin
      line_done_r <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_line) begin
            sent_state <= bus.state;
            sent_score <= bus.score;
            byte_idx   <= 3'd0;
            clk_cnt    <= '0;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            fsm        <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            tx_r    <= cur_byte[0];
            fsm     <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_r <= 1'b1;
              fsm  <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx_r    <= cur_byte[next_bit];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx < 3'd6) begin
              byte_idx <= byte_idx + 3'd1;
              tx_r     <= 1'b0;
              fsm      <= START;
            end else begin
              busy_r      <= 1'b0;
              line_done_r <= 1'b1;
              fsm         <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.tx        = tx_r;
  assign bus.busy      = busy_r;
  assign bus.line_done = line_done_r;

endmodule
